// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if
//   Bundles the alarm controller's time/button inputs and its status outputs.
//   master: drives time, alarm setting, enable, buttons and the second tick
//   slave : the alarm controller itself
//   Signals: Sec_Tick, Time_BCD[15:0], Alarm_BCD[15:0], Alarm_En, Snooze,
//            Stop (to slave); Ringing, Snoozing, Buzzer (from slave).
interface alarm_ctrl_if;
  logic        Sec_Tick;
  logic [15:0] Time_BCD;
  logic [15:0] Alarm_BCD;
  logic        Alarm_En;
  logic        Snooze;
  logic        Stop;
  logic        Ringing;
  logic        Snoozing;
  logic        Buzzer;

  modport master (
    output Sec_Tick, Time_BCD, Alarm_BCD, Alarm_En, Snooze, Stop,
    input  Ringing, Snoozing, Buzzer
  );

  modport slave (
    input  Sec_Tick, Time_BCD, Alarm_BCD, Alarm_En, Snooze, Stop,
    output Ringing, Snoozing, Buzzer
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
//   Compares the BCD wall-clock time against the alarm setting and runs a
//   RING / SNOOZE state machine with second-based timeouts.
//   Ports:
//     Clk  - system clock, all state changes on posedge
//     Clr  - asynchronous active-low reset
//     bus  - alarm_ctrl_if.slave: Sec_Tick, Time_BCD, Alarm_BCD, Alarm_En,
//            Snooze, Stop in; Ringing, Snoozing, Buzzer out (all registered)
//   Parameters:
//     SNOOZE_SEC - snooze length in Sec_Tick pulses (1..65535)
//     RING_SEC   - auto-stop ring length in Sec_Tick pulses (1..65535)
module alarm_ctrl #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic         Clk,
  input  logic         Clr,
  alarm_ctrl_if.slave  bus
);

  localparam logic [15:0] RING_LD   = RING_SEC[15:0];
  localparam logic [15:0] SNOOZE_LD = SNOOZE_SEC[15:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t      state;
  logic        match_q, snooze_q, stop_q;
  logic [15:0] ring_cnt, snooze_cnt;

  logic match, trigger, snz_e, stp_e;

  // Raw compare, no BCD validity check; the alarm fires once per entry
  // into the matching minute because trigger needs a rising match.
  assign match   = bus.Alarm_En & (bus.Time_BCD == bus.Alarm_BCD);
  assign trigger = match & ~match_q;
  assign snz_e   = bus.Snooze & ~snooze_q;
  assign stp_e   = bus.Stop & ~stop_q;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state        <= IDLE;
      match_q      <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
      ring_cnt     <= '0;
      snooze_cnt   <= '0;
      bus.Ringing  <= 1'b0;
      bus.Snoozing <= 1'b0;
      bus.Buzzer   <= 1'b0;
    end else begin
      match_q  <= match;
      snooze_q <= bus.Snooze;
      stop_q   <= bus.Stop;
      case (state)
        IDLE: begin
          if (trigger) begin
            state       <= RING;
            ring_cnt    <= RING_LD;
            bus.Ringing <= 1'b1;
            bus.Buzzer  <= 1'b1;
          end
        end
        RING: begin
          // Button edges outrank the tick, so a coincident tick is dropped.
          if (!bus.Alarm_En || stp_e) begin
            state       <= IDLE;
            bus.Ringing <= 1'b0;
            bus.Buzzer  <= 1'b0;
          end else if (snz_e) begin
            state        <= SNOOZE;
            snooze_cnt   <= SNOOZE_LD;
            bus.Ringing  <= 1'b0;
            bus.Snoozing <= 1'b1;
            bus.Buzzer   <= 1'b0;
          end else if (bus.Sec_Tick && ring_cnt == 16'd1) begin
            state       <= IDLE;
            bus.Ringing <= 1'b0;
            bus.Buzzer  <= 1'b0;
          end else if (bus.Sec_Tick) begin
            ring_cnt   <= ring_cnt - 16'd1;
            bus.Buzzer <= ~bus.Buzzer;
          end
        end
        SNOOZE: begin
          if (!bus.Alarm_En || stp_e) begin
            state        <= IDLE;
            bus.Snoozing <= 1'b0;
            bus.Buzzer   <= 1'b0;
          end else if (bus.Sec_Tick && snooze_cnt == 16'd1) begin
            state        <= RING;
            ring_cnt     <= RING_LD;
            bus.Snoozing <= 1'b0;
            bus.Ringing  <= 1'b1;
            bus.Buzzer   <= 1'b1;
          end else if (bus.Sec_Tick) begin
            snooze_cnt <= snooze_cnt - 16'd1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.Ringing  <= 1'b0;
          bus.Snoozing <= 1'b0;
          bus.Buzzer   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;
  localparam int SNZ_S  = 3;
  localparam int RING_S = 4;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  always #5 Clk = ~Clk;

  alarm_ctrl_if bus();

  alarm_ctrl #(.SNOOZE_SEC(SNZ_S), .RING_SEC(RING_S)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: tracks whether we are ringing/snoozing and how many
  // seconds have elapsed in the current phase; buzzer is on for even counts.
  bit m_ring, m_snz;
  int m_rsec, m_ssec;
  bit p_match, p_snz, p_stp;

  function automatic void model_reset();
    m_ring = 0; m_snz = 0; m_rsec = 0; m_ssec = 0;
    p_match = 0; p_snz = 0; p_stp = 0;
  endfunction

  function automatic void model_edge();
    bit mt, trig, se, te;
    mt   = bus.Alarm_En && (bus.Time_BCD == bus.Alarm_BCD);
    trig = mt && !p_match;
    se   = bus.Snooze && !p_snz;
    te   = bus.Stop && !p_stp;
    if (m_ring) begin
      if (!bus.Alarm_En || te) m_ring = 0;
      else if (se) begin m_ring = 0; m_snz = 1; m_ssec = 0; end
      else if (bus.Sec_Tick) begin
        m_rsec++;
        if (m_rsec == RING_S) m_ring = 0;
      end
    end else if (m_snz) begin
      if (!bus.Alarm_En || te) m_snz = 0;
      else if (bus.Sec_Tick) begin
        m_ssec++;
        if (m_ssec == SNZ_S) begin m_snz = 0; m_ring = 1; m_rsec = 0; end
      end
    end else if (trig) begin
      m_ring = 1; m_rsec = 0;
    end
    p_match = mt; p_snz = bus.Snooze; p_stp = bus.Stop;
  endfunction

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("ringing",  {31'd0, bus.Ringing},  {31'd0, m_ring});
    chk("snoozing", {31'd0, bus.Snoozing}, {31'd0, m_snz});
    chk("buzzer",   {31'd0, bus.Buzzer},   {31'd0, (m_ring && (m_rsec % 2 == 0))});
  endtask

  task automatic tick_step();
    bus.Sec_Tick = 1'b1;
    step();
    bus.Sec_Tick = 1'b0;
  endtask

  // Called just after an edge: pulls Clr low between edges.
  task automatic mid_reset();
    #2 Clr = 1'b0;
    model_reset();
    #1;
    chk("rst_ringing",  {31'd0, bus.Ringing},  32'd0);
    chk("rst_snoozing", {31'd0, bus.Snoozing}, 32'd0);
    chk("rst_buzzer",   {31'd0, bus.Buzzer},   32'd0);
    #1 Clr = 1'b1;
  endtask

  task automatic ring_up();
    bus.Time_BCD = 16'h0731; step();
    bus.Time_BCD = 16'h0730; step();
  endtask

  initial begin
    model_reset();
    bus.Sec_Tick  = 1'b0;
    bus.Time_BCD  = 16'h0729;
    bus.Alarm_BCD = 16'h0730;
    bus.Alarm_En  = 1'b1;
    bus.Snooze    = 1'b0;
    bus.Stop      = 1'b0;
    #12;
    chk("por_ringing", {31'd0, bus.Ringing}, 32'd0);
    chk("por_buzzer",  {31'd0, bus.Buzzer},  32'd0);
    Clr = 1'b1;
    step();

    // Trigger and beep pattern
    bus.Time_BCD = 16'h0730; step();
    chk("trig_ring", {31'd0, bus.Ringing}, 32'd1);
    chk("trig_buzz", {31'd0, bus.Buzzer},  32'd1);
    tick_step(); chk("beep1", {31'd0, bus.Buzzer}, 32'd0);
    tick_step(); chk("beep2", {31'd0, bus.Buzzer}, 32'd1);
    tick_step(); chk("beep3", {31'd0, bus.Buzzer}, 32'd0);

    // Held Stop acts once, no retrigger while minute still matches
    bus.Stop = 1'b1;
    step(); chk("stop_idle", {31'd0, bus.Ringing}, 32'd0);
    repeat (4) step();
    bus.Stop = 1'b0;
    step(); chk("no_rering", {31'd0, bus.Ringing}, 32'd0);
    ring_up(); chk("rering", {31'd0, bus.Ringing}, 32'd1);

    // Snooze; second press ignored; wake on 3rd tick
    bus.Snooze = 1'b1; step();
    chk("snz_on",   {31'd0, bus.Snoozing}, 32'd1);
    chk("snz_buzz", {31'd0, bus.Buzzer},   32'd0);
    bus.Snooze = 1'b0; step();
    bus.Snooze = 1'b1; step();
    chk("snz_again", {31'd0, bus.Snoozing}, 32'd1);
    bus.Snooze = 1'b0;
    tick_step(); tick_step();
    chk("snz_wait", {31'd0, bus.Ringing}, 32'd0);
    tick_step();
    chk("wake_ring", {31'd0, bus.Ringing}, 32'd1);
    chk("wake_buzz", {31'd0, bus.Buzzer},  32'd1);

    // Timeout on the RING_S-th tick
    repeat (RING_S - 1) tick_step();
    chk("pre_timeout", {31'd0, bus.Ringing}, 32'd1);
    tick_step();
    chk("timeout", {31'd0, bus.Ringing}, 32'd0);

    // Stop + Snooze together -> IDLE
    ring_up();
    bus.Stop = 1'b1; bus.Snooze = 1'b1; step();
    chk("both_ring", {31'd0, bus.Ringing},  32'd0);
    chk("both_snz",  {31'd0, bus.Snoozing}, 32'd0);
    bus.Stop = 1'b0; bus.Snooze = 1'b0; step();

    // Tick coincident with Snooze: full snooze length still applies
    ring_up();
    bus.Snooze = 1'b1; bus.Sec_Tick = 1'b1; step();
    bus.Snooze = 1'b0; bus.Sec_Tick = 1'b0;
    chk("tick_snz", {31'd0, bus.Snoozing}, 32'd1);
    tick_step(); tick_step();
    chk("tick_snz_hold", {31'd0, bus.Snoozing}, 32'd1);
    tick_step();
    chk("tick_snz_wake", {31'd0, bus.Ringing}, 32'd1);

    // Alarm_En drop during SNOOZE
    bus.Snooze = 1'b1; step(); bus.Snooze = 1'b0;
    bus.Alarm_En = 1'b0; step();
    chk("en_drop", {31'd0, bus.Snoozing}, 32'd0);
    bus.Alarm_En = 1'b1; step();

    // Async reset mid-ring, then stays idle with non-matching time
    ring_up();
    bus.Time_BCD = 16'h0731;
    mid_reset();
    repeat (3) step();
    chk("post_rst_idle", {31'd0, bus.Ringing}, 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.Time_BCD = (r < 5) ? 16'h0730 : (r < 9) ? 16'h0731 : 16'($urandom);
      if ($urandom_range(0, 99) == 0) bus.Alarm_BCD = ($urandom_range(0, 1) == 0) ? 16'h0730 : 16'h0731;
      bus.Alarm_En = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 5) == 0) bus.Snooze = ~bus.Snooze;
      if ($urandom_range(0, 7) == 0) bus.Stop = ~bus.Stop;
      bus.Sec_Tick = ($urandom_range(0, 2) == 0);
      step();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
